// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read-side, flush and packed-output signals of fifo_rd_packer.
//   fifo_empty / fifo_rd_en / fifo_rd_data : upstream FIFO read port
//   flush / flush_done                     : partial-word flush request and completion pulse
//   out_data / out_keep / out_valid / out_ready : packed output stream with lane mask
// Modport master is the packer's view; modport slave is the surrounding environment.
interface fifo_rd_packer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4
);
  logic                             fifo_empty;
  logic                             fifo_rd_en;
  logic [DATA_WIDTH-1:0]            fifo_rd_data;
  logic                             flush;
  logic                             flush_done;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic [PACK_RATIO-1:0]            out_keep;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    input  fifo_empty, fifo_rd_data, flush, out_ready,
    output fifo_rd_en, flush_done, out_data, out_keep, out_valid
  );

  modport slave (
    output fifo_empty, fifo_rd_data, flush, out_ready,
    input  fifo_rd_en, flush_done, out_data, out_keep, out_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs PACK_RATIO consecutive FIFO read words (lanes) into one wide output word.
// First lane read lands in the least significant lane. A flush emits a partial word with
// out_keep marking the filled lanes, then pulses flush_done.
// Ports:
//   clk  : FIFO read-side clock, sole clock
//   rst  : synchronous active-high reset
//   bus  : fifo_rd_packer_if.master (FIFO read port, flush, packed output stream)
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_rd_packer_if.master  bus
);
  localparam int unsigned CntW = $clog2(PACK_RATIO + 1);
  localparam int unsigned OutW = DATA_WIDTH * PACK_RATIO;

  logic [CntW-1:0]                        fill_cnt_q, fill_cnt_d, eff_fill;
  logic [CntW:0]                          occupancy;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]  asm_q, asm_d;
  logic [OutW-1:0]                        out_data_q, out_data_d;
  logic [PACK_RATIO-1:0]                  out_keep_q, out_keep_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   rd_pend_q;
  logic                                   flush_req_q, flush_req_d;
  logic                                   flush_done_q, flush_done_d;
  logic                                   full, xfer_req, xfer, rd_en, rd_acc, flush_fin;

  assign full     = (fill_cnt_q == CntW'(PACK_RATIO));
  // Flush may only emit once the in-flight lane has landed.
  assign xfer_req = full || (flush_req_q && !rd_pend_q && (fill_cnt_q != '0));
  assign xfer     = xfer_req && (!out_valid_q || bus.out_ready);
  // A transfer empties the assembly this cycle, so reads may resume immediately.
  assign eff_fill = xfer ? '0 : fill_cnt_q;
  // Count the in-flight lane so the assembly can never be overrun.
  assign occupancy = {1'b0, eff_fill} + {{CntW{1'b0}}, rd_pend_q};
  assign rd_en     = !rst && !bus.fifo_empty && !flush_req_q &&
                     (occupancy < (CntW + 1)'(PACK_RATIO));
  assign rd_acc    = rd_en && !bus.fifo_empty;
  assign flush_fin = flush_req_q && !rd_pend_q && ((fill_cnt_q == '0) || xfer);

  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    asm_d        = asm_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q;
    flush_req_d  = flush_req_q;
    flush_done_d = flush_fin;

    if (rd_pend_q) begin
      for (int i = 0; i < int'(PACK_RATIO); i++) begin
        if (fill_cnt_q == CntW'(i)) asm_d[i] = bus.fifo_rd_data;
      end
      fill_cnt_d = fill_cnt_q + CntW'(1);
    end

    if (xfer) begin
      // Assembly is cleared after each transfer, so unfilled lanes are already zero.
      out_data_d  = asm_q;
      for (int i = 0; i < int'(PACK_RATIO); i++) begin
        out_keep_d[i] = (CntW'(i) < fill_cnt_q);
      end
      out_valid_d = 1'b1;
      fill_cnt_d  = '0;
      asm_d       = '0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush_fin) begin
      flush_req_d = 1'b0;
    end else if (bus.flush) begin
      flush_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q   <= '0;
      asm_q        <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      flush_req_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      asm_q        <= asm_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
      rd_pend_q    <= rd_acc;
      flush_req_q  <= flush_req_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.flush_done = flush_done_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_keep   = out_keep_q;
  assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_packer_if #(.DATA_WIDTH(8), .PACK_RATIO(4)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  fifo_q[$];
  int          beats, dones;
  logic [31:0] last_data;
  logic [3:0]  last_keep;

  typedef struct {
    logic [31:0] bytes;
    int          n;
    bit          do_flush;
    int          exp_beats;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: FIFO model answers accepted reads with data valid the next cycle.
  task automatic tick();
    bit acc;
    #1;
    acc = bus.fifo_rd_en && !bus.fifo_empty;
    @(posedge clk);
    #1;
    if (acc) bus.fifo_rd_data = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
    #1;
    if (bus.out_valid && bus.out_ready) begin
      beats++;
      last_data = bus.out_data;
      last_keep = bus.out_keep;
    end
    if (bus.flush_done) dones++;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    beats = 0; dones = 0; last_data = '0; last_keep = '0;
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h44332211, 4, 1'b0, 1, 32'h44332211, 4'hf};
    vecs[1] = '{32'h00C3B2A1, 3, 1'b1, 1, 32'h00C3B2A1, 4'h7};
    vecs[2] = '{32'h0000005A, 1, 1'b1, 1, 32'h0000005A, 4'h1};
    vecs[3] = '{32'h0000ADDE, 2, 1'b1, 1, 32'h0000ADDE, 4'h3};
    vecs[4] = '{32'hF0E0D0C0, 4, 1'b1, 1, 32'hF0E0D0C0, 4'hf};
    vecs[5] = '{32'h87654321, 4, 1'b0, 1, 32'h87654321, 4'hf};

    rst = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    clr();
    collect(2);
    push(8'h99);
    #1;
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_keep", 64'(bus.out_keep), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_done", 64'(bus.flush_done), 64'd0);
    // Drain the probe byte through a flush.
    bus.out_ready = 1'b1;
    collect(4);
    clr();
    flush_pulse();
    collect(6);
    chk("probe_data", 64'(last_data), 64'h99);
    chk("probe_keep", 64'(last_keep), 64'h1);

    // Table-driven transactions
    for (int v = 0; v < 6; v++) begin
      clr();
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].bytes[8*i +: 8]);
      if (vecs[v].do_flush) begin
        collect(6);
        flush_pulse();
        collect(8);
      end else begin
        collect(12);
      end
      chk($sformatf("v%0d_beats", v), 64'(beats), 64'(vecs[v].exp_beats));
      chk($sformatf("v%0d_data", v), 64'(last_data), 64'(vecs[v].exp_data));
      chk($sformatf("v%0d_keep", v), 64'(last_keep), 64'(vecs[v].exp_keep));
      chk($sformatf("v%0d_dones", v), 64'(dones), 64'(vecs[v].do_flush));
    end

    // Partial flush blocks reads until completion; flush_done is a single pulse
    clr();
    push(8'hA1); push(8'hB2); push(8'hC3);
    collect(6);
    flush_pulse();
    push(8'hEE);
    #1;
    chk("pf_rd_blocked", 64'(bus.fifo_rd_en), 64'd0);
    tick();
    chk("pf_valid", 64'(bus.out_valid), 64'd1);
    chk("pf_data", 64'(bus.out_data), 64'h00C3B2A1);
    chk("pf_keep", 64'(bus.out_keep), 64'h7);
    chk("pf_done", 64'(bus.flush_done), 64'd1);
    tick();
    chk("pf_done_pulse", 64'(bus.flush_done), 64'd0);
    clr();
    flush_pulse();
    collect(6);
    chk("pf_tail_data", 64'(last_data), 64'hEE);
    chk("pf_tail_keep", 64'(last_keep), 64'h1);

    // Empty flush: done two cycles after flush, no output
    clr();
    flush_pulse();
    chk("ef_done_early", 64'(bus.flush_done), 64'd0);
    tick();
    chk("ef_done", 64'(bus.flush_done), 64'd1);
    chk("ef_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("ef_done_pulse", 64'(bus.flush_done), 64'd0);
    chk("ef_beats", 64'(beats), 64'd0);

    // Flush in the same cycle as an accepted read
    push(8'h10);
    collect(3);
    clr();
    push(8'h20);
    flush_pulse();
    #1;
    chk("fr_rd_blocked", 64'(bus.fifo_rd_en), 64'd0);
    collect(6);
    chk("fr_beats", 64'(beats), 64'd1);
    chk("fr_data", 64'(last_data), 64'h00002010);
    chk("fr_keep", 64'(last_keep), 64'h3);
    chk("fr_dones", 64'(dones), 64'd1);

    // Backpressure: first word held, reads stop once second assembly is full
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i));
    collect(12);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_data", 64'(bus.out_data), 64'h04030201);
    chk("bp_keep", 64'(bus.out_keep), 64'hf);
    chk("bp_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("bp_not_empty", 64'(bus.fifo_empty), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), 64'(bus.out_data), 64'h04030201);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_w2_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_w2_data", 64'(bus.out_data), 64'h08070605);
    tick();
    chk("bp_w2_gone", 64'(bus.out_valid), 64'd0);
    clr();
    flush_pulse();
    collect(6);
    chk("bp_tail_data", 64'(last_data), 64'h09);
    chk("bp_tail_keep", 64'(last_keep), 64'h1);

    // Reset with fill_cnt=2 and out_valid=1
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h31 + 8'(i));
    collect(8);
    chk("mr_pre_valid", 64'(bus.out_valid), 64'd1);
    push(8'h77);
    rst = 1'b1;
    #1;
    chk("mr_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    tick();
    rst = 1'b0;
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_keep", 64'(bus.out_keep), 64'd0);
    chk("mr_data", 64'(bus.out_data), 64'd0);
    bus.out_ready = 1'b1;
    clr();
    push(8'h78); push(8'h79); push(8'h7A);
    collect(12);
    chk("mr_beats", 64'(beats), 64'd1);
    chk("mr_fresh_data", 64'(last_data), 64'h7A797877);
    chk("mr_fresh_keep", 64'(last_keep), 64'hf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
